alu_result_sink: RTL and testbench

ALU_RESULT_SINK -- requirements
Module: alu_result_sink

---
 rtl/alu_result_sink.sv | 171 +++++++++++++++++
 tb/tb_alu_result_sink.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_sink.sv
// alu_result_sink: buffers ALU results in a small FIFO for a downstream
// consumer. It also keeps statistics on every accepted result: saturating
// event counters, a 32-bit MISR signature, and a sticky flag that is set
// when a result's zero flag disagrees with its value.
module alu_result_sink #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:31]      in_result,
  input  logic [0:3]       in_ctrl,
  input  logic             in_zero,
  input  logic             in_of,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:31]      out_result,
  output logic [0:3]       out_ctrl,
  output logic             out_zero,
  output logic             out_of,

  input  logic             clear,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] zero_cnt,
  output logic [CNT_W-1:0] of_cnt,
  output logic [0:31]      signature,
  output logic             flag_err
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [0:31]     SIG_SEED = 32'hFFFF_FFFF;
  localparam logic [0:31]     SIG_POLY = 32'h0040_0007;

  typedef struct packed {
    logic [0:31] result;
    logic [0:3]  ctrl;
    logic        zero;
    logic        of;
  } entry_t;

  // FIFO storage and bookkeeping
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Statistics
  logic [CNT_W-1:0] total_cnt_q, total_cnt_d;
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
  logic [CNT_W-1:0] of_cnt_q, of_cnt_d;
  logic [0:31]      sig_q, sig_d;
  logic             err_q, err_d;

  logic push;
  logic pop;
  logic zero_mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Handshakes: ready is gated by reset so nothing is offered while held in reset;
  // it never looks at out_ready, so a full FIFO cannot be bypassed.
  assign in_ready  = rst_n && (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // The head comes straight from storage, so a newly written entry shows up right after its edge
  assign out_result = mem_q[rd_ptr_q].result;
  assign out_ctrl   = mem_q[rd_ptr_q].ctrl;
  assign out_zero   = mem_q[rd_ptr_q].zero;
  assign out_of     = mem_q[rd_ptr_q].of;

  assign total_cnt = total_cnt_q;
  assign zero_cnt  = zero_cnt_q;
  assign of_cnt    = of_cnt_q;
  assign signature = sig_q;
  assign flag_err  = err_q;

  // FIFO next-state: pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q].result = in_result;
      mem_d[wr_ptr_q].ctrl   = in_ctrl;
      mem_d[wr_ptr_q].zero   = in_zero;
      mem_d[wr_ptr_q].of     = in_of;
      wr_ptr_d               = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Statistics next-state: clear takes priority over a coincident accept
  always_comb begin
    total_cnt_d   = total_cnt_q;
    zero_cnt_d    = zero_cnt_q;
    of_cnt_d      = of_cnt_q;
    sig_d         = sig_q;
    err_d         = err_q;
    zero_mismatch = (in_zero != (in_result == 32'h0));
    if (clear) begin
      total_cnt_d = '0;
      zero_cnt_d  = '0;
      of_cnt_d    = '0;
      sig_d       = SIG_SEED;
      err_d       = 1'b0;
    end else if (push) begin
      total_cnt_d = sat_inc(total_cnt_q);
      if (in_zero) zero_cnt_d = sat_inc(zero_cnt_q);
      if (in_of)   of_cnt_d   = sat_inc(of_cnt_q);
      sig_d = (sig_q << 1) ^ (sig_q[0] ? SIG_POLY : 32'h0) ^ in_result;
      err_d = err_q | zero_mismatch;
    end
  end

  // Entry storage has no reset; an empty count makes stale contents invisible
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // FIFO control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_cnt_q <= '0;
      zero_cnt_q  <= '0;
      of_cnt_q    <= '0;
      sig_q       <= SIG_SEED;
      err_q       <= 1'b0;
    end else begin
      total_cnt_q <= total_cnt_d;
      zero_cnt_q  <= zero_cnt_d;
      of_cnt_q    <= of_cnt_d;
      sig_q       <= sig_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_result_sink.sv
// Bench for alu_result_sink: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_alu_result_sink;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = 65535;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [0:31]      in_result = 32'h0;
  logic [0:3]       in_ctrl = 4'h0;
  logic             in_zero = 1'b0;
  logic             in_of = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [0:31]      out_result;
  logic [0:3]       out_ctrl;
  logic             out_zero;
  logic             out_of;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] total_cnt;
  logic [CNT_W-1:0] zero_cnt;
  logic [CNT_W-1:0] of_cnt;
  logic [0:31]      signature;
  logic             flag_err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  alu_result_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_ctrl(in_ctrl), .in_zero(in_zero), .in_of(in_of),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ctrl(out_ctrl), .out_zero(out_zero), .out_of(out_of),
    .clear(clear), .total_cnt(total_cnt), .zero_cnt(zero_cnt), .of_cnt(of_cnt),
    .signature(signature), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words and plain integer statistics
  typedef struct {
    logic [0:31] r;
    logic [0:3]  c;
    logic        z;
    logic        o;
  } ent_t;

  ent_t        m_q[$];
  int          m_total = 0;
  int          m_zero  = 0;
  int          m_of    = 0;
  logic [0:31] m_sig   = 32'hFFFF_FFFF;
  logic        m_err   = 1'b0;
  bit          m_acc;
  ent_t        m_e;

  function automatic logic [0:31] misr(input logic [0:31] s, input logic [0:31] d);
    logic [0:31] fb;
    fb = s[0] ? 32'h0040_0007 : 32'h0;
    return (s << 1) ^ fb ^ d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_total = 0;
      m_zero  = 0;
      m_of    = 0;
      m_sig   = 32'hFFFF_FFFF;
      m_err   = 1'b0;
    end else begin
      m_acc = in_valid && (m_q.size() < DEPTH);
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (m_acc) begin
        m_e.r = in_result; m_e.c = in_ctrl; m_e.z = in_zero; m_e.o = in_of;
        m_q.push_back(m_e);
      end
      if (clear) begin
        m_total = 0; m_zero = 0; m_of = 0;
        m_sig = 32'hFFFF_FFFF;
        m_err = 1'b0;
      end else if (m_acc) begin
        if (m_total < CNT_MAX) m_total++;
        if (in_zero && m_zero < CNT_MAX) m_zero++;
        if (in_of && m_of < CNT_MAX) m_of++;
        m_sig = misr(m_sig, in_result);
        if (in_zero != (in_result == 32'h0)) m_err = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, rst_n && (m_q.size() < DEPTH));
      check("out_valid", out_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        check("out_result", out_result, m_q[0].r);
        check("out_ctrl", out_ctrl, m_q[0].c);
        check("out_zero", out_zero, m_q[0].z);
        check("out_of", out_of, m_q[0].o);
      end
      check("total_cnt", total_cnt, 64'(m_total));
      check("zero_cnt", zero_cnt, 64'(m_zero));
      check("of_cnt", of_cnt, 64'(m_of));
      check("signature", signature, m_sig);
      check("flag_err", flag_err, m_err);
    end
  end

  // One clock of stimulus; returns shortly after the rising edge it spans
  task automatic step(input logic v, input logic [0:31] r, input logic [0:3] c,
                      input logic z, input logic o, input logic ordy, input logic clr);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_result = r;
    in_ctrl   = c;
    in_zero   = z;
    in_of     = o;
    out_ready = ordy;
    clear     = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic ordy, input logic clr);
    step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, ordy, clr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [0:31] words [5];
  logic [0:31] ordw  [4];

  initial begin
    words[0] = 32'h1111_1111; words[1] = 32'h2222_2222; words[2] = 32'h0000_0000;
    words[3] = 32'h4444_4444; words[4] = 32'h5555_5555;

    // Reset state
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst in_ready", in_ready, 1'b0);
    check("rst out_valid", out_valid, 1'b0);
    check("rst signature", signature, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("ready after release", in_ready, 1'b1);

    // Single zero word: known signature, one-cycle latency
    step(1'b1, 32'h0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sig after zero push", signature, 32'hFFBF_FFF9);
    check("zero_cnt one", zero_cnt, 16'd1);
    check("total_cnt one", total_cnt, 16'd1);
    check("flag_err clean", flag_err, 1'b0);
    check("out_valid latency", out_valid, 1'b1);
    check("out_ctrl fwd", out_ctrl, 4'h3);
    idle(1'b1, 1'b0);
    check("empty after pop", out_valid, 1'b0);

    // Zero flag inconsistent with a nonzero word
    step(1'b1, 32'h8ccd_1c83, 4'h9, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flag_err set", flag_err, 1'b1);
    idle(1'b1, 1'b0);
    check("flag_err sticky", flag_err, 1'b1);
    idle(1'b1, 1'b1);
    check("flag_err cleared", flag_err, 1'b0);
    check("total cleared", total_cnt, 16'd0);

    // Fill with out_ready low: fifth word is refused, then drain in order
    for (int i = 0; i < 5; i++) begin
      step(1'b1, words[i], 4'(i), (words[i] == 32'h0), i[0], 1'b0, 1'b0);
      if (i == 2) check("ready before full", in_ready, 1'b1);
    end
    check("ready when full", in_ready, 1'b0);
    check("fifth held", total_cnt, 16'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain order", out_result, words[i]);
      idle(1'b1, 1'b0);
    end
    check("drained", out_valid, 1'b0);

    // Full FIFO with a pending word and a consumer: pop first, push next cycle
    for (int i = 0; i < 4; i++) ordw[i] = 32'hA000_0001 + 32'(i);
    for (int i = 0; i < 4; i++) step(1'b1, ordw[i], 4'hA, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hA000_0005, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pop only when full", in_ready, 1'b1);
    check("head after pop", out_result, 32'hA000_0002);
    step(1'b1, 32'hA000_0005, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    check("refilled", in_ready, 1'b0);
    check("head stable", out_result, 32'hA000_0002);
    idle(1'b0, 1'b0);
    check("head held", out_result, 32'hA000_0002);
    for (int i = 0; i < 4; i++) begin
      check("order kept", out_result, (i < 3) ? ordw[i+1] : 32'hA000_0005);
      idle(1'b1, 1'b0);
    end

    // Clear coinciding with an accept: stats clear, word still stored
    step(1'b1, 32'h1234_5678, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1);
    check("clear wins total", total_cnt, 16'd0);
    check("clear wins of", of_cnt, 16'd0);
    check("clear wins sig", signature, 32'hFFFF_FFFF);
    check("word still pushed", out_result, 32'h1234_5678);
    check("of forwarded", out_of, 1'b1);

    // Clear does not flush the FIFO
    idle(1'b0, 1'b1);
    check("clear keeps fifo", out_valid, 1'b1);
    step(1'b1, 32'h0000_0007, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-transfer discards everything
    @(negedge clk);
    #1;
    in_valid = 1'b1; in_result = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    #1;
    check("mid rst out_valid", out_valid, 1'b0);
    check("mid rst in_ready", in_ready, 1'b0);
    check("mid rst sig", signature, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle(1'b0, 1'b0);
    check("no stale entry", out_valid, 1'b0);
    check("total after rst", total_cnt, 16'd0);

    // Saturation: push 65537 zero words with the consumer always ready
    for (int i = 0; i < 65537; i++) step(1'b1, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("zero_cnt saturates", zero_cnt, 16'hFFFF);
    check("total_cnt saturates", total_cnt, 16'hFFFF);
    check("of_cnt saturates", of_cnt, 16'hFFFF);
    idle(1'b1, 1'b1);
    check("clear after sat", zero_cnt, 16'd0);

    idle(1'b1, 1'b0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
